// File: rtl/counter_load_pkg.sv
// Shared types and defaults for the counter load controller.
// Optional feature macro used by the top: CLC_WRAP_COUNT_EN.
package counter_load_pkg;

  localparam int CLC_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    VERIFY = 2'd2,
    WATCH  = 2'd3
  } state_t;

endpackage

// File: rtl/counter_load_ctrl_if.sv
// Load-request handshake between the control logic and the counter load controller.
interface counter_load_ctrl_if
  import counter_load_pkg::*;
#(
  parameter int WIDTH = CLC_WIDTH
) ();

  logic             req_valid;
  logic [WIDTH-1:0] req_value;
  logic             req_ready;

  modport master (output req_valid, output req_value, input  req_ready);
  modport slave  (input  req_valid, input  req_value, output req_ready);

endinterface

// File: rtl/counter_load_ctrl.sv
// Loads a value into an external up-counter, then checks it counts +1 per cycle until it wraps to 0.
// Define CLC_WRAP_COUNT_EN to add the wrap_cycles output (WATCH cycle count of the last sequence).
module counter_load_ctrl
  import counter_load_pkg::*;
#(
  parameter int WIDTH    = CLC_WIDTH,
  parameter int MAX_WAIT = (1 << WIDTH) + 2
) (
  input  logic               clk,
  input  logic               rst_n,
  counter_load_ctrl_if.slave req,
  output logic               ld_en,
  output logic [WIDTH-1:0]   load,
  input  logic [WIDTH-1:0]   cnt_in,
  output logic               busy,
  output logic               done,
  output logic               err
`ifdef CLC_WRAP_COUNT_EN
  ,
  output logic [WIDTH:0]     wrap_cycles
`endif
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
  localparam logic [WIDTH-1:0]  EXP_ONE   = WIDTH'(1);

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    exp_q, exp_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [WIDTH-1:0]    load_q, load_d;
  logic                ld_en_q, ld_en_d;
  logic                ready_q, ready_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                accept;
`ifdef CLC_WRAP_COUNT_EN
  logic [WIDTH:0]      wrap_q, wrap_d;
`endif

  assign accept        = (state_q == IDLE) && ready_q && req.req_valid;
  assign req.req_ready = ready_q;
  assign ld_en         = ld_en_q;
  assign load          = load_q;
  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign err           = err_q;
`ifdef CLC_WRAP_COUNT_EN
  assign wrap_cycles   = wrap_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      exp_q   <= '0;
      wait_q  <= '0;
      load_q  <= '0;
      ld_en_q <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef CLC_WRAP_COUNT_EN
      wrap_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      wait_q  <= wait_d;
      load_q  <= load_d;
      ld_en_q <= ld_en_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef CLC_WRAP_COUNT_EN
      wrap_q  <= wrap_d;
`endif
    end
  end

  // Ready follows the current state, not the next one, so it reappears one cycle after done.
  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    wait_d  = wait_q;
    load_d  = load_q;
    ld_en_d = 1'b0;
    ready_d = 1'b0;
    done_d  = 1'b0;
    err_d   = err_q;
`ifdef CLC_WRAP_COUNT_EN
    wrap_d  = wrap_q;
`endif
    case (state_q)
      IDLE: begin
        ready_d = !accept;
        if (accept) begin
          exp_d   = req.req_value;
          load_d  = req.req_value;
          ld_en_d = 1'b1;
          err_d   = 1'b0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        state_d = VERIFY;
      end
      // A zero here is the loaded value, never a wrap.
      VERIFY: begin
        if (cnt_in != exp_q) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
`ifdef CLC_WRAP_COUNT_EN
          wrap_d  = '0;
`endif
        end else begin
          exp_d   = exp_q + EXP_ONE;
          wait_d  = '0;
          state_d = WATCH;
        end
      end
      WATCH: begin
        if ((cnt_in != exp_q) || (cnt_in == '0) || (wait_q == WAIT_LAST)) begin
          err_d   = (cnt_in != exp_q) || (cnt_in != '0);
          done_d  = 1'b1;
          state_d = IDLE;
`ifdef CLC_WRAP_COUNT_EN
          wrap_d  = (WIDTH+1)'(wait_q + WAIT_ONE);
`endif
        end else begin
          exp_d  = exp_q + EXP_ONE;
          wait_d = wait_q + WAIT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_counter_load_ctrl.sv
// Scoreboard bench for counter_load_ctrl: stimulus queues expected loads/completions, a monitor checks them.
module tb_counter_load_ctrl;

  typedef struct {
    logic err;
    int   lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ld_en;
  logic [3:0] load;
  logic [3:0] cnt_in;
  logic       busy;
  logic       done;
  logic       err;
`ifdef CLC_WRAP_COUNT_EN
  logic [4:0] wrap_cycles;
`endif

  counter_load_ctrl_if #(.WIDTH(4)) req_if ();

  counter_load_ctrl #(.WIDTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req_if),
    .ld_en       (ld_en),
    .load        (load),
    .cnt_in      (cnt_in),
    .busy        (busy),
    .done        (done),
    .err         (err)
`ifdef CLC_WRAP_COUNT_EN
    ,
    .wrap_cycles (wrap_cycles)
`endif
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int acc_count = 0;
  int last_done_cyc = 0;
  bit have_done = 1'b0;
  bit chk_gap = 1'b0;
  logic [3:0] ldq[$];
  exp_t doneq[$];

  // Counter under test: mode 0 normal, 1 ignores loads and shows hold_val, 2 sticks at stall_val.
  int mode = 0;
  logic [3:0] hold_val = 4'd0;
  logic [3:0] stall_val = 4'd0;
  logic [3:0] cnt_q = 4'd0;

  always @(posedge clk) begin
    if (ld_en)
      cnt_q <= load;
    else if (!(mode == 2 && cnt_q == stall_val))
      cnt_q <= cnt_q + 4'd1;
  end

  assign cnt_in = (mode == 1) ? hold_val : cnt_q;

  task automatic checkOutput(input string name, input int actual, input int expected);
    total_cnt++;
    if (actual == expected)
      pass_cnt++;
    else
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // Accepts are sampled at the edge itself; outputs are sampled on the falling edge.
  initial begin
    logic [3:0] exp_ld;
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst_n && req_if.req_valid && req_if.req_ready) begin
        acc_count++;
        if (chk_gap && have_done)
          checkOutput("accept_gap", cyc - last_done_cyc, 2);
        acc_cyc = cyc;
      end
      @(negedge clk);
      if (ld_en) begin
        if (ldq.size() == 0) begin
          checkOutput("unexpected_ld_en", 1, 0);
        end else begin
          exp_ld = ldq.pop_front();
          checkOutput("load_value", int'(load), int'(exp_ld));
          checkOutput("ld_en_cycle", cyc - acc_cyc, 0);
        end
      end
      if (done) begin
        have_done = 1'b1;
        last_done_cyc = cyc;
        if (doneq.size() == 0) begin
          checkOutput("unexpected_done", 1, 0);
        end else begin
          e = doneq.pop_front();
          checkOutput("done_err", int'(err), int'(e.err));
          checkOutput("done_latency", cyc - acc_cyc, e.lat);
        end
      end
    end
  end

  task automatic waitDone();
    int n = 0;
    while (doneq.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (doneq.size() != 0) begin
      checkOutput("done_timeout", 0, 1);
      doneq.delete();
      ldq.delete();
    end
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [3:0] v, input int m, input logic [3:0] aux,
                               input logic e_err, input int e_lat, input bit track_done);
    int n = 0;
    @(negedge clk);
    mode = m;
    hold_val = aux;
    stall_val = aux;
    ldq.push_back(v);
    if (track_done) doneq.push_back('{err: e_err, lat: e_lat});
    req_if.req_value = v;
    req_if.req_valid = 1'b1;
    while (!req_if.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_if.req_ready) begin
      checkOutput("accept_timeout", 0, 1);
      req_if.req_valid = 1'b0;
      ldq.delete();
      doneq.delete();
      return;
    end
    @(negedge clk);
    req_if.req_valid = 1'b0;
    if (track_done) waitDone();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    int start;
    int n;
    req_if.req_valid = 1'b0;
    req_if.req_value = 4'd0;

    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_ld_en", int'(ld_en), 0);
    checkOutput("rst_ready", int'(req_if.req_ready), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_err", int'(err), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset in the middle of WATCH: everything clears at once and no done follows.
    applyStimulus(4'd5, 0, 4'd0, 1'b0, 0, 1'b0);
    repeat (4) @(negedge clk);
    checkOutput("mid_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_ld_en", int'(ld_en), 0);
    checkOutput("mid_rst_load", int'(load), 0);
    checkOutput("mid_rst_busy", int'(busy), 0);
    checkOutput("mid_rst_done", int'(done), 0);
    checkOutput("mid_rst_ready", int'(req_if.req_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 checkOutput("rel_ready_low", int'(req_if.req_ready), 0);
    @(negedge clk);
    checkOutput("rel_ready_high", int'(req_if.req_ready), 1);

    applyStimulus(4'd3, 0, 4'd0, 1'b0, 15, 1'b1);
    applyStimulus(4'd15, 0, 4'd0, 1'b0, 3, 1'b1);
    applyStimulus(4'd0, 0, 4'd0, 1'b0, 18, 1'b1);
    applyStimulus(4'd3, 1, 4'd6, 1'b1, 2, 1'b1);
    repeat (3) @(negedge clk);
    checkOutput("err_sticky", int'(err), 1);
    applyStimulus(4'd6, 2, 4'd9, 1'b1, 6, 1'b1);
    applyStimulus(4'd7, 2, 4'd7, 1'b1, 3, 1'b1);
    applyStimulus(4'd10, 0, 4'd0, 1'b0, 8, 1'b1);
    checkOutput("err_cleared", int'(err), 0);

    // Request held high: one accept per IDLE visit, the second two cycles after done.
    @(negedge clk);
    mode = 0;
    start = acc_count;
    ldq.push_back(4'd14);
    ldq.push_back(4'd14);
    doneq.push_back('{err: 1'b0, lat: 4});
    doneq.push_back('{err: 1'b0, lat: 4});
    req_if.req_value = 4'd14;
    req_if.req_valid = 1'b1;
    n = 0;
    while (acc_count < start + 1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk_gap = 1'b1;
    while (acc_count < start + 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk_gap = 1'b0;
    req_if.req_valid = 1'b0;
    checkOutput("held_accepts", acc_count - start, 2);
    waitDone();
    repeat (3) @(negedge clk);
    checkOutput("held_no_extra", acc_count - start, 2);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
